// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back source identifiers.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;
  localparam int NUM_WB_SRC = 3;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr (mod N).
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] blocked_s;

  // Distance of source i from the pointer in round-robin search order.
  function automatic int rr_dist(input int i, input int p);
    return (i + N - p) % N;
  endfunction

  // A requester wins unless another requester sits closer to the pointer.
  always_comb begin
    blocked_s = '0;
    gnt       = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked_s[i] = blocked_s[i] |
                       (req[j] && (rr_dist(j, int'(ptr)) < rr_dist(i, int'(ptr))));
      end
      gnt[i] = en & req[i] & ~blocked_s[i];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port.
// Optional WBARB_FWD_EN adds fwd_valid/fwd_addr/fwd_data bypass outputs.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = NUM_WB_SRC,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata
`ifdef WBARB_FWD_EN
  ,
  output logic                      fwd_valid,
  output logic [ADDR_W-1:0]         fwd_addr,
  output logic [DATA_W-1:0]         fwd_data
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   ptr_nxt_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               arb_en_s;
  logic               any_gnt_s;
  logic               drop_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;

  // Reset gates the arbiter so requests pending during reset are never consumed.
  assign arb_en_s = ~wb_hold & ~rst;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_r),
    .en  (arb_en_s),
    .gnt (gnt_s)
  );

  assign req_ready = gnt_s;

  // One-hot select of the granted source's address, data and index.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    gnt_idx_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_W{gnt_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
      sel_data_s = sel_data_s | ({DATA_W{gnt_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      gnt_idx_s  = gnt_idx_s | (gnt_s[i] ? PTR_W'(i) : '0);
    end
  end

  assign any_gnt_s = |gnt_s;
  assign ptr_nxt_s = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
  assign drop_s    = DISCARD_R0 && (sel_addr_s == ADDR_W'(REG_ZERO));

  // Pointer and registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any_gnt_s) begin
      ptr_r    <= ptr_nxt_s;
      rf_we    <= ~drop_s;
      rf_waddr <= sel_addr_s;
      rf_wdata <= sel_data_s;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WBARB_FWD_EN
  assign fwd_valid = rf_we && (rf_waddr != ADDR_W'(REG_ZERO));
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between several write-back sources (ALU, load/store unit, multiply/divide unit).
- Each source presents a valid/ready request. A round-robin arbiter grants one request per cycle.
- The granted write is registered and driven onto the register file's write port (we / write_addr / write_data) one cycle later.
- Sits between the execute-stage units and the 32x32 register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- DISCARD_R0, 1, when 1, writes to register 0 are accepted but never reach the register file.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_hold  in  1  pipeline hold; while high, no request is granted.
- req_valid  in  NUM_REQ  per-source write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; source i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; the request is consumed in the cycle valid&ready.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- fwd_valid, fwd_addr, fwd_data  out  1/ADDR_W/DATA_W  present only with WBARB_FWD_EN.

Behaviour:
- Reset: rst is sampled on clk. While rst is high:
  - req_ready = 0.
  - Outputs clear next edge: rf_we=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer clears to 0.
  - Requests pending at reset are not granted and not remembered.
- Handshake rules:
  - Sources hold req_valid, req_addr and req_data stable until ready.
  - Deasserting valid without a grant is legal: the request is withdrawn, with no side effect.
- Grant (combinational, cycle t):
  - If wb_hold=0 and any valid: grant the first valid source searching from ptr upward, modulo NUM_REQ.
  - req_ready is one-hot on that source, else all zero.
  - req_ready never depends on rf outputs, so there is no combinational loop.
- Pointer update:
  - On a grant to source g at edge end of t, ptr <= (g+1) mod NUM_REQ.
  - No grant: ptr unchanged.
- Write stage (edge end of t), when a grant occurs:
  - rf_waddr <= granted addr; rf_wdata <= granted data.
  - rf_we <= 1, except rf_we <= 0 when DISCARD_R0=1 and addr=0.
- No grant: rf_we <= 0; rf_waddr and rf_wdata hold their previous values.
- Latency: the register file contents update at end of cycle t+1; a read of that address returns the new value from cycle t+2.
- Throughput: one write per cycle sustained. With all sources valid, each is served at least once every NUM_REQ cycles (no starvation).
- Simultaneous requests to the same address: served one at a time in round-robin order. Ordering between sources is the issuing pipeline's responsibility; the arbiter does not reorder or merge.
- wb_hold:
  - Suppresses grants only. An already-registered write still completes (rf_we stays as registered for t+1).
  - The pointer is frozen while held.
- Single-source case: a continuously valid source is granted every cycle.

Optional Feature:
- Macro: WBARB_FWD_EN.
- Defined: fwd_valid/fwd_addr/fwd_data mirror rf_we/rf_waddr/rf_wdata combinationally. Decode uses them to bypass the t+1 write, so a same-cycle read sees the new value. fwd_valid is forced 0 for address 0 regardless of DISCARD_R0.
- Undefined: these three ports do not exist, and read-after-write needs the t+2 spacing.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MDU=2, NUM_WB_SRC=3.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr, en. Output: one-hot gnt.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset then single write: src1 valid, addr=7, data=32'hDEADBEEF → ready[1] in cycle t; rf_we=1, rf_waddr=7, rf_wdata=32'hDEADBEEF in t+1; rf_we=0 in t+2.
- All 3 sources continuously valid from ptr=0 → grant order 0,1,2,0,1,2 for 6 cycles; each rf write carries its source's data.
- Sources 0 and 2 valid, ptr=1 → src2 granted first, then src0; rf_waddr sequence matches.
- wb_hold=1 for 3 cycles with src0 valid → ready=0 and rf_we=0 for those cycles; grant on the first cycle after hold drops; ptr unchanged.
- Write to addr 0 with DISCARD_R0=1 → ready asserted, rf_we stays 0; with WBARB_FWD_EN, a write to addr 5 gives fwd_valid=1, fwd_addr=5 in t+1.
- rst asserted in cycle t while src1 is valid → no grant in t; rf_we=0 at t+1; after release, src0 (ptr=0) wins over src1 if both are valid.
